mult_result_recombiner: RTL and testbench

//  Consumer end of the split-output multiplier interface (result_0/result_1/result_SIDM_carry).

---
 rtl/mult_result_recombiner_pkg.sv | 35 +++
 rtl/mult_result_recombiner_if.sv | 36 +++
 rtl/mult_lane_splitter.sv | 53 +++++
 rtl/mult_result_recombiner.sv | 146 ++++++++++++++
 tb/tb_mult_result_recombiner.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_result_recombiner_pkg.sv
// Shared constants and types for the multiplier result recombiner.
// Holds mode encodings, per-mode lane widths, FSM state encoding, the P1 beat record
// and the bad-beat classification helper.
package mult_recomb_pkg;

  localparam logic [1:0] MODE_18x12   = 2'b00;
  localparam logic [1:0] MODE_SUM_6x6 = 2'b01;
  localparam logic [1:0] MODE_SUM_3x3 = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam int unsigned LANE_W_18X12 = 30;
  localparam int unsigned LANE_W_6X6   = 14;
  localparam int unsigned LANE_W_3X3   = 8;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  // One accepted multiplier beat as held in the P1 stage.
  typedef struct packed {
    logic [1:0]  mode;
    logic        sgn;
    logic        bad;
    logic [7:0]  carry;
    logic [29:0] r1;
    logic [29:0] r0;
  } beat_t;

  // A beat is discarded (counted, contributes zero) if it disagrees with the group
  // mode or uses the reserved encoding.
  function automatic logic beat_is_bad(input logic [1:0] beat_mode, input logic [1:0] grp_mode);
    return (beat_mode != grp_mode) || (beat_mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/mult_result_recombiner_if.sv
// Bus between the split-output multiplier (master) and the recombiner (slave).
// Input side: in_valid/in_ready handshake with mode, signedness, two partial results,
// SIDM carries and group length. Output side: out_valid/out_ready with group mode,
// four lane totals (lane0 in LSBs), group error flag and a per-bad-beat pulse.
interface mult_result_recombiner_if #(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         mode;
  logic               a_sign;
  logic               b_sign;
  logic [29:0]        result_0;
  logic [29:0]        result_1;
  logic [7:0]         result_SIDM_carry;
  logic [CNT_W-1:0]   len;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_mode;
  logic [4*ACC_W-1:0] out_acc;
  logic               out_err;
  logic               err_mode;

  modport master (
    output in_valid, mode, a_sign, b_sign, result_0, result_1, result_SIDM_carry, len,
    output out_ready,
    input  in_ready, out_valid, out_mode, out_acc, out_err, err_mode
  );

  modport slave (
    input  in_valid, mode, a_sign, b_sign, result_0, result_1, result_SIDM_carry, len,
    input  out_ready,
    output in_ready, out_valid, out_mode, out_acc, out_err, err_mode
  );
endinterface

// File: rtl/mult_lane_splitter.sv
// Combinational recombination of the two partial results plus SIDM carries into
// four lane values, sign- or zero-extended to ACC_W.
// Ports: mode_i (lane layout), sgn_i (signed extension), r0_i/r1_i (partial results),
// carry_i (2 carry bits per 6-bit segment), lanes_o (lane3..lane0, each ACC_W).
module mult_lane_splitter
  import mult_recomb_pkg::*;
#(
  parameter int unsigned ACC_W = 48
) (
  input  logic [1:0]            mode_i,
  input  logic                  sgn_i,
  input  logic [29:0]           r0_i,
  input  logic [29:0]           r1_i,
  input  logic [7:0]            carry_i,
  output logic [3:0][ACC_W-1:0] lanes_o
);

  logic [LANE_W_18X12-1:0] l18;
  logic [19:0]             s6_lo;
  logic [LANE_W_6X6-1:0]   s6_hi;
  logic [13:0]             s3_lo;
  logic [LANE_W_3X3-1:0]   s3_1, s3_2, s3_3;

  always_comb begin
    l18   = r0_i + r1_i;
    // Low lanes carry their sum into the upper bits; the lane value sits above bit 6.
    s6_lo = {carry_i[3:2], r0_i[17:0]} + {2'b00, r1_i[17:0]};
    s6_hi = {carry_i[7:6], r0_i[29:18]} + {2'b00, r1_i[29:18]};
    s3_lo = {carry_i[1:0], r0_i[11:0]} + {2'b00, r1_i[11:0]};
    s3_1  = {carry_i[3:2], r0_i[17:12]} + {2'b00, r1_i[17:12]};
    s3_2  = {carry_i[5:4], r0_i[23:18]} + {2'b00, r1_i[23:18]};
    s3_3  = {carry_i[7:6], r0_i[29:24]} + {2'b00, r1_i[29:24]};

    lanes_o = '0;
    case (mode_i)
      MODE_18x12: begin
        lanes_o[0] = {{(ACC_W-30){sgn_i & l18[29]}}, l18};
      end
      MODE_SUM_6x6: begin
        lanes_o[0] = {{(ACC_W-14){sgn_i & s6_lo[19]}}, s6_lo[19:6]};
        lanes_o[1] = {{(ACC_W-14){sgn_i & s6_hi[13]}}, s6_hi};
      end
      MODE_SUM_3x3: begin
        lanes_o[0] = {{(ACC_W-8){sgn_i & s3_lo[13]}}, s3_lo[13:6]};
        lanes_o[1] = {{(ACC_W-8){sgn_i & s3_1[7]}}, s3_1};
        lanes_o[2] = {{(ACC_W-8){sgn_i & s3_2[7]}}, s3_2};
        lanes_o[3] = {{(ACC_W-8){sgn_i & s3_3[7]}}, s3_3};
      end
      default: lanes_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_result_recombiner.sv
// Consumer of the split-output multiplier. Accepts beats, registers them into P1,
// accumulates len beats per lane as one dot-product group and presents the totals
// on a valid/ready output.
// Ports: clk, reset (async, active-high), bus_io (slave side of the recombiner bus).
module mult_result_recombiner
  import mult_recomb_pkg::*;
#(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 8
) (
  input logic clk,
  input logic reset,
  mult_result_recombiner_if.slave bus_io
);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  beat_t                 p1_q, p1_d;
  logic                  p1_valid_q, p1_valid_d;
  logic [3:0][ACC_W-1:0] acc_q, acc_d;
  logic                  err_q, err_d;
  logic                  err_pulse_q, err_pulse_d;

  logic                  accept;
  logic                  first_beat;
  logic                  last_beat;
  logic [1:0]            grp_mode;
  logic [CNT_W-1:0]      eff_len;
  logic [3:0][ACC_W-1:0] lanes;

  assign bus_io.in_ready  = (state_q == COLLECT) && !reset;
  assign bus_io.out_valid = (state_q == EMIT);
  assign bus_io.out_mode  = mode_q;
  assign bus_io.out_acc   = acc_q;
  assign bus_io.out_err   = err_q;
  assign bus_io.err_mode  = err_pulse_q;

  always_comb begin
    accept     = bus_io.in_valid && bus_io.in_ready;
    first_beat = (count_q == '0);
    // Mode and len come straight from the bus on the first beat, then from the latch.
    grp_mode   = first_beat ? bus_io.mode : mode_q;
    eff_len    = first_beat ? bus_io.len : len_q;
    if (eff_len == '0) begin
      eff_len = CNT_W'(1);
    end
    last_beat  = ((count_q + CNT_W'(1)) == eff_len);
  end

  always_comb begin
    p1_valid_d = accept;
    p1_d       = p1_q;
    if (accept) begin
      p1_d.mode  = bus_io.mode;
      p1_d.sgn   = bus_io.a_sign | bus_io.b_sign;
      p1_d.bad   = beat_is_bad(bus_io.mode, grp_mode);
      p1_d.carry = bus_io.result_SIDM_carry;
      p1_d.r1    = bus_io.result_1;
      p1_d.r0    = bus_io.result_0;
    end
  end

  mult_lane_splitter #(
    .ACC_W(ACC_W)
  ) u_splitter (
    .mode_i (p1_q.mode),
    .sgn_i  (p1_q.sgn),
    .r0_i   (p1_q.r0),
    .r1_i   (p1_q.r1),
    .carry_i(p1_q.carry),
    .lanes_o(lanes)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;

    if (p1_valid_q) begin
      if (p1_q.bad) begin
        err_pulse_d = 1'b1;
        err_d       = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          acc_d[i] = acc_q[i] + lanes[i];
        end
      end
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (first_beat) begin
            mode_d = bus_io.mode;
            len_d  = eff_len;
          end
          count_d = count_q + CNT_W'(1);
          if (last_beat) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = EMIT;
      EMIT: begin
        if (bus_io.out_ready) begin
          state_d = COLLECT;
          count_d = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      len_q       <= '0;
      mode_q      <= MODE_18x12;
      p1_q        <= '0;
      p1_valid_q  <= 1'b0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      p1_q        <= p1_d;
      p1_valid_q  <= p1_valid_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule

// File: tb/tb_mult_result_recombiner.sv
// Directed-vector bench for mult_result_recombiner with a queue-based scoreboard.
module tb_mult_result_recombiner;

  localparam int unsigned ACC_W = 48;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned AW    = 4 * ACC_W;

  typedef struct {
    logic [AW-1:0] acc;
    logic [1:0]    mode;
    logic          err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   err_pulses;
  exp_t exp_q[$];

  mult_result_recombiner_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mult_result_recombiner #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [ACC_W-1:0] l3, input logic [ACC_W-1:0] l2,
                              input logic [ACC_W-1:0] l1, input logic [ACC_W-1:0] l0,
                              input logic [1:0] m, input logic e);
    exp_t x;
    x.acc  = {l3, l2, l1, l0};
    x.mode = m;
    x.err  = e;
    return x;
  endfunction

  // Scoreboard monitor: compares on every output handshake.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", AW'(1), AW'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_acc", bus.out_acc, e.acc);
        check("out_mode", AW'(bus.out_mode), AW'(e.mode));
        check("out_err", AW'(bus.out_err), AW'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.err_mode) err_pulses++;
  end

  task automatic send(input logic [1:0] m, input logic sg, input logic [29:0] r0,
                      input logic [29:0] r1, input logic [7:0] c, input logic [7:0] ln,
                      output int waited);
    waited = 0;
    bus.in_valid          = 1'b1;
    bus.mode              = m;
    bus.a_sign            = sg;
    bus.b_sign            = 1'b0;
    bus.result_0          = r0;
    bus.result_1          = r1;
    bus.result_SIDM_carry = c;
    bus.len               = ln;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check("in_ready_timeout", AW'(0), AW'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", AW'(exp_q.size()), AW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    n_checks   = 0;
    n_pass     = 0;
    err_pulses = 0;
    reset      = 1'b1;
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    bus.a_sign = 1'b0;
    bus.b_sign = 1'b0;
    bus.result_0 = '0;
    bus.result_1 = '0;
    bus.result_SIDM_carry = '0;
    bus.len = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", AW'(bus.in_ready), AW'(0));
    check("rst_out_valid", AW'(bus.out_valid), AW'(0));
    check("rst_out_acc", bus.out_acc, AW'(0));
    check("rst_out_err", AW'(bus.out_err), AW'(0));
    check("rst_err_mode", AW'(bus.err_mode), AW'(0));
    check("rst_out_mode", AW'(bus.out_mode), AW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: 18x12 signed, -15, with output latency
    exp_q.push_back(mk('0, '0, '0, 48'hFFFF_FFFF_FFF1, 2'b00, 1'b0));
    send(2'b00, 1'b1, 30'h3FFF_FFF1, 30'h0, 8'h00, 8'd1, w);
    check("t1_valid_edge1", AW'(bus.out_valid), AW'(0));
    @(posedge clk);
    #1;
    check("t1_valid_edge2", AW'(bus.out_valid), AW'(1));
    wait_drain();

    // 2: 6x6 unsigned, carry from low segment lands in lane0
    exp_q.push_back(mk('0, '0, '0, 48'd4096, 2'b01, 1'b0));
    send(2'b01, 1'b0, 30'h3FFC0, 30'h00040, 8'h00, 8'd1, w);
    wait_drain();

    // 3: 3x3 unsigned, four back-to-back beats into lane3
    exp_q.push_back(mk(48'd512, '0, '0, '0, 2'b10, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send(2'b10, 1'b0, 30'h3F00_0000, 30'h0100_0000, 8'h40, 8'd4, w);
      check($sformatf("t3_ready_beat%0d", i), AW'(w), AW'(0));
    end
    wait_drain();

    // 4: backpressure, then a fresh group with no residue
    bus.out_ready = 1'b0;
    exp_q.push_back(mk('0, '0, '0, 48'd5, 2'b00, 1'b0));
    send(2'b00, 1'b0, 30'd2, 30'd3, 8'h00, 8'd1, w);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", AW'(bus.out_valid), AW'(1));
      check("t4_hold_ready", AW'(bus.in_ready), AW'(0));
      check("t4_hold_acc", bus.out_acc, {144'd0, 48'd5});
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    exp_q.push_back(mk('0, '0, '0, 48'd7, 2'b00, 1'b0));
    send(2'b00, 1'b0, 30'd7, 30'd0, 8'h00, 8'd1, w);
    wait_drain();

    // 5: mismatched mode mid-group
    err_pulses = 0;
    exp_q.push_back(mk('0, '0, '0, 48'd30, 2'b00, 1'b1));
    send(2'b00, 1'b1, 30'd10, 30'd1, 8'h00, 8'd3, w);
    send(2'b01, 1'b1, 30'd100, 30'd0, 8'h00, 8'd9, w);
    send(2'b00, 1'b1, 30'd20, 30'h3FFF_FFFF, 8'h00, 8'd9, w);
    wait_drain();
    check("t5_err_pulses", AW'(err_pulses), AW'(1));

    // 6: reset mid-group discards partial work
    send(2'b00, 1'b0, 30'd100, 30'd0, 8'h00, 8'd4, w);
    send(2'b00, 1'b0, 30'd100, 30'd0, 8'h00, 8'd4, w);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", AW'(bus.in_ready), AW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(mk('0, '0, '0, 48'd9, 2'b00, 1'b0));
    send(2'b00, 1'b0, 30'd9, 30'd0, 8'h00, 8'd1, w);
    wait_drain();

    // 7: len=0 acts as 1; 3x3 signed lane1 = 8'hFF -> -1
    exp_q.push_back(mk('0, '0, 48'hFFFF_FFFF_FFFF, '0, 2'b10, 1'b0));
    send(2'b10, 1'b1, 30'h3F000, 30'h0, 8'h0C, 8'd0, w);
    wait_drain();

    // 8: reserved mode on first beat zeroes the whole group
    err_pulses = 0;
    exp_q.push_back(mk('0, '0, '0, '0, 2'b11, 1'b1));
    send(2'b11, 1'b0, 30'd55, 30'd1, 8'hFF, 8'd2, w);
    send(2'b00, 1'b0, 30'd5, 30'd1, 8'h00, 8'd2, w);
    wait_drain();
    check("t8_err_pulses", AW'(err_pulses), AW'(2));

    check("sb_empty", AW'(exp_q.size()), AW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
